// File: rtl/sq_wave_sequencer.sv
// Steps a square-wave generator through a table of (m,n) entries,
// holding each for a set number of periods counted on wave_in rises.
// Ports: clk/rst (async, active low); wr_* table write; last_idx, loop,
// start, stop control; wave_in feedback; m/n, cur_idx, busy, done, err out.
module sq_wave_sequencer #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [M-1:0]  wr_m,
  input  logic [N-1:0]  wr_n,
  input  logic [CW-1:0] wr_reps,
  input  logic [AW-1:0] last_idx,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic          wave_in,
  output logic [M-1:0]  m,
  output logic [N-1:0]  n,
  output logic [AW-1:0] cur_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [M-1:0]  tm [DEPTH];
  logic [N-1:0]  tn [DEPTH];
  logic [CW-1:0] tr [DEPTH];

  logic          wave_q;
  logic          first;
  logic          played;
  logic          loop_q;
  logic [AW-1:0] last_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] reps_q;

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      tm[wr_addr] <= wr_m;
      tn[wr_addr] <= wr_n;
      tr[wr_addr] <= wr_reps;
    end
  end

  logic [M-1:0]  e_m;
  logic [N-1:0]  e_n;
  logic [CW-1:0] e_r;
  logic          rise;
  logic          skip;
  logic [CW-1:0] cnt_inc;
  logic [AW-1:0] last_cl;
  logic          adv;
  logic [AW-1:0] adv_idx;
  state_t        adv_st;
  logic          adv_done;
  logic          adv_err;
  logic          adv_clrp;

  always_comb begin
    e_m     = tm[cur_idx];
    e_n     = tn[cur_idx];
    e_r     = tr[cur_idx];
    rise    = wave_in & ~wave_q;
    skip    = (e_r == '0) || (e_m == '0) || (e_n == '0);
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    last_cl = (32'(last_idx) > DEPTH - 1) ? AW'(DEPTH - 1) : last_idx;
    adv     = ((state == LOAD) && skip) ||
              ((state == RUN) && rise && !first &&
               (cnt_inc == reps_q));
  end

  // Where to go once the current entry is finished or skipped.
  always_comb begin
    adv_idx  = cur_idx;
    adv_st   = LOAD;
    adv_done = 1'b0;
    adv_err  = 1'b0;
    adv_clrp = 1'b0;
    if (cur_idx != last_q) begin
      adv_idx = cur_idx + 1'b1;
    end else if (loop_q) begin
      if (!played) begin
        // whole pass had nothing playable: give up
        adv_st  = IDLE;
        adv_err = 1'b1;
      end else begin
        adv_idx  = '0;
        adv_clrp = 1'b1;
      end
    end else begin
      adv_st   = IDLE;
      adv_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      m       <= '0;
      n       <= '0;
      cur_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wave_q  <= 1'b0;
      first   <= 1'b0;
      played  <= 1'b0;
      loop_q  <= 1'b0;
      last_q  <= '0;
      cnt     <= '0;
      reps_q  <= '0;
    end else begin
      wave_q <= wave_in;
      done   <= 1'b0;
      if (stop && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        m     <= '0;
        n     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            m <= '0;
            n <= '0;
            if (start && !stop) begin
              state   <= LOAD;
              busy    <= 1'b1;
              cur_idx <= '0;
              last_q  <= last_cl;
              loop_q  <= loop;
              err     <= 1'b0;
              first   <= 1'b1;
              played  <= 1'b0;
            end
          end
          LOAD: begin
            if (!skip) begin
              m      <= e_m;
              n      <= e_n;
              reps_q <= e_r;
              cnt    <= '0;
              played <= 1'b1;
              state  <= RUN;
            end else if (e_r != '0) begin
              err <= 1'b1;
            end
          end
          RUN: begin
            if (rise) begin
              // first rise after start only aligns to the wave
              if (first) first <= 1'b0;
              else       cnt   <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
        if (adv) begin
          state   <= adv_st;
          cur_idx <= adv_idx;
          if (adv_st == IDLE) begin
            busy <= 1'b0;
            m    <= '0;
            n    <= '0;
          end
          if (adv_done) done   <= 1'b1;
          if (adv_err)  err    <= 1'b1;
          if (adv_clrp) played <= 1'b0;
        end
      end
    end
  end

endmodule
